// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg
// Shared FSM state type and default operand width for the bit-serial adder.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fa_cell.sv
// ============================================================================
// fa_cell
// Single combinational 1-bit full adder shared across all bit positions.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// serial_adder_ctrl
// Bit-serial add (LSB first) with valid/ready operand and result handshakes.
// Optional subtract mode selected by macro SERIAL_ADDER_SUB_EN.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic w_fa_s;
  logic w_fa_c;

  fa_cell u_fa_cell (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (w_fa_s),
    .c   (w_fa_c)
  );

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d    = a;
          bit_cnt_d = '0;
          state_d   = RUN;
`ifdef SERIAL_ADDER_SUB_EN
          // a - b computed as a + ~b + 1; cout then reads as NOT borrow
          b_sh_d  = sub ? ~b : b;
          carry_d = sub | cin;
`else
          b_sh_d  = b;
          carry_d = cin;
`endif
        end
      end
      RUN: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        sum_sh_d  = {w_fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d   = w_fa_c;
        cout_d    = w_fa_c;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_sh_q;
  assign cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// tb_serial_adder_ctrl
// Directed and random checks of serial_adder_ctrl against an arithmetic model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modular arithmetic on a WIDTH+1 bit result.
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic ci, input logic sb);
    logic [W:0] r;
    logic [W-1:0] nb;
    nb = ~bv;
    if (sb) r = {1'b0, av} + {1'b0, nb} + (W+1)'(1);
    else    r = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb, input int hold);
    logic [W:0] exp;
    int n;
    int bad_busy;
    exp = model(av, bv, ci, sb);
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check_eq({tag, "_in_ready_wait"}, 32'(in_ready), 32'd1);
    start = 1'b1; a = av; b = bv; cin = ci; sub = sb;
    step();
    start = 1'b0;
    n = 0;
    bad_busy = 0;
    while (!out_valid && n < 40) begin
      if (!busy || in_ready) bad_busy++;
      step();
      n++;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'(W));
    check_eq({tag, "_busy_run"}, 32'(bad_busy), 32'd0);
    check_eq({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
    check_eq({tag, "_cout"}, 32'(cout), 32'(exp[W]));
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) step();
    check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'b10);
    check_eq({tag, "_sum_kept"}, 32'({cout, sum}), 32'(exp));
  endtask

  initial begin
    int n;
    int bad;
    int seen_valid;
    logic [W:0] exp;
    logic [W:0] exp2;
    logic sb_r;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    step(); step();
    check_eq("reset_state", {27'd0, in_ready, out_valid, busy, cout, 1'b0}, {27'd0, 5'b10000});
    check_eq("reset_sum", 32'(sum), 32'd0);
    rst_n = 1'b1;
    step();

    run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 2);

    // Backpressure with start pulsing new operands while DONE
    exp = model(8'h12, 8'h34, 1'b1, 1'b0);
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1; sub = 1'b0;
    step();
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    check_eq("bp_latency", 32'(n), 32'(W));
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1;
      step();
      if (!out_valid || in_ready || sum !== exp[W-1:0] || cout !== exp[W]) bad++;
    end
    start = 1'b0;
    check_eq("bp_frozen", 32'(bad), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
    step(); step();
    check_eq("bp_no_capture", {30'd0, busy, in_ready}, 32'b01);

    // Reset in the middle of RUN
    start = 1'b1; a = 8'hC3; b = 8'h3C; cin = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("rst_mid_ctrl", {28'd0, in_ready, out_valid, busy, cout}, 32'b1000);
    check_eq("rst_mid_sum", 32'(sum), 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen_valid++;
    end
    check_eq("rst_mid_no_result", 32'(seen_valid), 32'd0);

    // Back-to-back: start held high, second op must be taken on first IDLE edge
    exp  = model(8'h81, 8'h7F, 1'b0, 1'b0);
    exp2 = model(8'h2B, 8'h19, 1'b1, 1'b0);
    out_ready = 1'b1;
    start = 1'b1; a = 8'h81; b = 8'h7F; cin = 1'b0;
    step();
    a = 8'h2B; b = 8'h19; cin = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    check_eq("b2b_first_latency", 32'(n), 32'(W));
    check_eq("b2b_first_res", 32'({cout, sum}), 32'(exp));
    n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    check_eq("b2b_idle_seen", 32'(in_ready), 32'd1);
    step();
    start = 1'b0;
    check_eq("b2b_second_accept", {30'd0, busy, in_ready}, 32'b10);
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    check_eq("b2b_second_latency", 32'(n), 32'(W));
    check_eq("b2b_second_res", 32'({cout, sum}), 32'(exp2));
    step();
    out_ready = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 0);
    check_eq("sub_10_01_lit", 32'({cout, sum}), 32'h10F);
    run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 0);
    check_eq("sub_01_02_lit", 32'({cout, sum}), 32'h0FF);
    run_op("sub_01_02_c0", 8'h01, 8'h02, 1'b0, 1'b1, 0);
    check_eq("sub_cin_ignored", 32'({cout, sum}), 32'h0FF);
`endif

    for (int k = 0; k < 20; k++) begin
`ifdef SERIAL_ADDER_SUB_EN
      sb_r = 1'($urandom_range(0, 1));
`else
      sb_r = 1'b0;
`endif
      run_op($sformatf("rand%0d", k), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
             sb_r, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
